midi_cmd_encoder: RTL



---
 rtl/midi_cmd_encoder_if.sv | 20 ++
 rtl/midi_cmd_encoder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/midi_cmd_encoder_if.sv
// rtl/midi_cmd_encoder_if.sv - byte input / command word output bundle of the MIDI command encoder
interface midi_cmd_encoder_if;
   logic [7:0]  i_byte;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] o_data;
   logic        o_valid;
   logic        o_err;
   logic [7:0]  o_drop_cnt;

   modport slave (
      input  i_byte, i_valid,
      output o_ready, o_data, o_valid, o_err, o_drop_cnt
   );

   modport master (
      output i_byte, i_valid,
      input  o_ready, o_data, o_valid, o_err, o_drop_cnt
   );
endinterface

// File: rtl/midi_cmd_encoder.sv
// rtl/midi_cmd_encoder.sv - MIDI byte parser, command FIFO and gap-spaced word emitter
module midi_cmd_encoder #(
   parameter int FIFO_DEPTH = 8,
   parameter int GAP        = 2,
   parameter int CHANNEL    = 0,
   parameter int OMNI       = 0
) (
   input  logic              clk,
   input  logic              reset,
   midi_cmd_encoder_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = $clog2(GAP + 1);

   typedef enum logic [1:0] {P_IDLE, P_D1, P_D2, P_SYX} p_state_t;
   typedef enum logic {E_IDLE, E_GAP} e_state_t;

   p_state_t       p_state_q, p_state_d;
   e_state_t       e_state_q, e_state_d;
   logic [7:0]     rs_q, rs_d;
   logic [6:0]     d1_q, d1_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [GW-1:0]  gap_q, gap_d;
   logic [15:0]    data_q, data_d;
   logic           valid_q, valid_d;
   logic           err_q, err_d;
   logic [7:0]     drop_q, drop_d;

   logic [15:0]    mem [FIFO_DEPTH];
   logic           ready, hs, complete, push, pop, chan_ok;
   logic [6:0]     note, vel;
   logic [15:0]    push_word;

   assign ready   = (cnt_q != CW'(FIFO_DEPTH));
   assign hs      = bus.i_valid && ready;
   assign chan_ok = (OMNI != 0) || (rs_q[3:0] == 4'(CHANNEL));

   always_comb begin
      p_state_d = p_state_q;
      rs_d      = rs_q;
      d1_d      = d1_q;
      err_d     = 1'b0;
      drop_d    = drop_q;
      complete  = 1'b0;
      note      = 7'd0;
      vel       = 7'd0;
      push      = 1'b0;
      push_word = 16'h0000;

      // Realtime bytes (F8-FF) fall through every branch untouched.
      if (hs && (bus.i_byte < 8'hF8)) begin
         if (p_state_q == P_SYX) begin
            if (bus.i_byte == 8'hF7) p_state_d = P_IDLE;
         end else if (bus.i_byte == 8'hF0) begin
            p_state_d = P_SYX;
            rs_d      = 8'h00;
         end else if (bus.i_byte[7:4] == 4'hF) begin
            p_state_d = P_IDLE;
            rs_d      = 8'h00;
         end else if (bus.i_byte[7]) begin
            p_state_d = P_D1;
            rs_d      = bus.i_byte;
         end else begin
            case (p_state_q)
               P_IDLE: err_d = 1'b1;
               P_D1: begin
                  if (rs_q[7:5] == 3'b110) begin
                     complete = 1'b1;
                     note     = bus.i_byte[6:0];
                  end else begin
                     d1_d      = bus.i_byte[6:0];
                     p_state_d = P_D2;
                  end
               end
               default: begin
                  complete  = 1'b1;
                  note      = d1_q;
                  vel       = bus.i_byte[6:0];
                  p_state_d = P_D1;
               end
            endcase
         end
      end

      if (complete && chan_ok) begin
         if (rs_q[7:5] == 3'b100) begin
            // Note 0 marks a free bank and 127 collides with STOP_ALL.
            if (note == 7'd0 || note == 7'd127) begin
               if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end else begin
               push      = 1'b1;
               push_word = (rs_q[4] && vel != 7'd0) ? {1'b1, note, 1'b0, vel}
                                                    : {1'b0, note, 8'h00};
            end
         end else if (rs_q[7:4] == 4'hB && (note == 7'd120 || note == 7'd123)) begin
            push      = 1'b1;
            push_word = 16'h7F00;
         end
      end
   end

   always_comb begin
      e_state_d = e_state_q;
      gap_d     = gap_q;
      data_d    = 16'h0000;
      valid_d   = 1'b0;
      pop       = 1'b0;
      case (e_state_q)
         E_IDLE: begin
            if (cnt_q != '0) begin
               pop       = 1'b1;
               data_d    = mem[rd_ptr_q];
               valid_d   = 1'b1;
               gap_d     = GW'(GAP);
               e_state_d = E_GAP;
            end
         end
         default: begin
            gap_d = gap_q - GW'(1);
            if (gap_q == GW'(1)) e_state_d = E_IDLE;
         end
      endcase
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      cnt_d    = cnt_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p_state_q <= P_IDLE;
         e_state_q <= E_IDLE;
         rs_q      <= 8'h00;
         d1_q      <= 7'd0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         gap_q     <= '0;
         data_q    <= 16'h0000;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         drop_q    <= 8'h00;
      end else begin
         p_state_q <= p_state_d;
         e_state_q <= e_state_d;
         rs_q      <= rs_d;
         d1_q      <= d1_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         drop_q    <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= push_word;
   end

   assign bus.o_ready    = ready;
   assign bus.o_data     = data_q;
   assign bus.o_valid    = valid_q;
   assign bus.o_err      = err_q;
   assign bus.o_drop_cnt = drop_q;
endmodule
